// File: rtl/uart_cmd_assembler_if.sv
// Byte-stream and command handshake bundle between the UART receiver, the
// command assembler and the command consumer.
interface uart_cmd_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        overrun;

  // Environment side: receiver bytes in, consumer acknowledge in.
  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, cmd_rdy, overrun
  );

  // Assembler side.
  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rx_rdy, cmd, cmd_rdy, overrun
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// Pairs received bytes (high then low) into 16-bit commands, with an inter-byte
// timeout that drops a stale high byte and a sticky overrun flag.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYC = 52080,
  parameter int unsigned TO_W        = 17
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_cmd_assembler_if.slave  bus
);

  typedef enum logic {StWaitHi = 1'b0, StWaitLo = 1'b1} state_e;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            overrun_q, overrun_d;
  logic            clr_rx_q, clr_rx_d;
  logic            accept, complete, timed_out;

  // The acknowledge cycle masks rx_rdy so a level-style strobe is taken once.
  assign accept    = bus.rx_rdy & ~clr_rx_q;
  assign complete  = (state_q == StWaitLo) & accept;
  assign timed_out = (state_q == StWaitLo) & ~accept & (to_cnt_q == ToLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitHi;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWaitHi: if (accept) state_d = StWaitLo;
      StWaitLo: if (complete || timed_out) state_d = StWaitHi;
      default:  state_d = StWaitHi;
    endcase
  end

  always_comb begin
    hold_d    = hold_q;
    to_cnt_d  = to_cnt_q;
    cmd_d     = cmd_q;
    clr_rx_d  = accept;
    case (state_q)
      StWaitHi: begin
        to_cnt_d = '0;
        if (accept) hold_d = bus.rx_data;
      end
      StWaitLo: begin
        if (accept || timed_out) begin
          to_cnt_d = '0;
        end else if (to_cnt_q != ToLast) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: to_cnt_d = '0;
    endcase
    if (complete) cmd_d = {hold_q, bus.rx_data};
    // A fresh command beats a simultaneous consumer acknowledge.
    if (complete)             cmd_rdy_d = 1'b1;
    else if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    else                      cmd_rdy_d = cmd_rdy_q;
    if (complete && cmd_rdy_q && !bus.clr_cmd_rdy) overrun_d = 1'b1;
    else if (bus.clr_cmd_rdy)                      overrun_d = 1'b0;
    else                                           overrun_d = overrun_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'h00;
      to_cnt_q  <= '0;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      clr_rx_q  <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      to_cnt_q  <= to_cnt_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
      clr_rx_q  <= clr_rx_d;
    end
  end

  assign bus.clr_rx_rdy = clr_rx_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART receiver and consumes its rx_rdy / rx_data byte stream.
- Assembles two consecutive bytes (high byte first, then low byte) into one 16-bit command word.
- Presents the command to the command-processing logic with a ready/clear handshake.
- Includes an inter-byte timeout that resynchronises the byte pairing after a lost or stray byte.

Parameters:
- TIMEOUT_CYC, 52080, clocks allowed between high-byte and low-byte capture before the high byte is discarded (about 2 byte times at 19200 baud, 50 MHz).
- TO_W, 17, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx_rdy  input  1  receiver byte-valid; may be a 1-cycle pulse or a level held until cleared.
- rx_data  input  8  received byte, valid while rx_rdy=1.
- clr_rx_rdy  output  1  1-cycle acknowledge to the receiver.
- cmd  output  16  assembled command, {high byte, low byte}.
- cmd_rdy  output  1  a new command is available.
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
- overrun  output  1  sticky flag: a command completed while cmd_rdy was still 1.

Behaviour:
- Reset values (async, rst_n=0): state=WAIT_HI, cmd=16'h0000, cmd_rdy=0, overrun=0, clr_rx_rdy=0, hold byte=8'h00, timeout count=0.
- Byte accept:
  - A byte is accepted in cycle N when rx_rdy=1 and clr_rx_rdy=0.
  - rx_data is registered at the end of cycle N.
  - clr_rx_rdy=1 for exactly cycle N+1.
  - While clr_rx_rdy=1, rx_rdy is ignored, so a level-style rx_rdy is never captured twice.
- WAIT_HI state:
  - Accepted byte goes to the hold register; next state is WAIT_LO.
  - Timeout counter is zeroed.
- WAIT_LO state:
  - Timeout counter increments by 1 each cycle no byte is accepted.
  - Accepted byte: cmd <= {hold, rx_data}; cmd_rdy=1 from cycle N+1; next state is WAIT_HI.
  - Counter reaching TIMEOUT_CYC-1 with no byte accepted: hold byte is discarded, next state is WAIT_HI, cmd and cmd_rdy are unchanged.
  - A byte accepted in the same cycle the counter reaches TIMEOUT_CYC-1 is taken as the low byte; acceptance wins over timeout.
- cmd latency: low byte sampled in cycle N; cmd and cmd_rdy updated by the edge ending N, so both are visible in N+1.
- cmd is held stable until the next completed pair; the hold register never drives cmd directly.
- cmd_rdy:
  - Set on completion; cleared on the cycle after clr_cmd_rdy=1.
  - If completion and clr_cmd_rdy coincide, the result is cmd_rdy=1 (the new command wins).
- overrun:
  - Set when completion occurs while cmd_rdy=1 and clr_cmd_rdy=0; the old cmd is overwritten.
  - Cleared by clr_cmd_rdy unless set in the same cycle.
- Reset asserted mid-pair returns to WAIT_HI immediately and discards any partial high byte.
- Counter saturation: the counter never exceeds TIMEOUT_CYC-1 and never wraps.
- States are encoded in 1 bit: WAIT_HI=0, WAIT_LO=1. No other states exist.

Test Plan:
- Reset, then pulse rx_rdy with 8'hA5; 1000 cycles later pulse rx_rdy with 8'h3C.
  - Required: clr_rx_rdy 1-cycle pulse after each byte.
  - Required: cmd=16'hA53C and cmd_rdy=1 one cycle after the second byte; overrun=0.
- Hold rx_rdy level high with data 8'h12 until clr_rx_rdy, then repeat with 8'h34.
  - Required: exactly two bytes accepted; cmd=16'h1234.
- Send byte 8'hFF, wait TIMEOUT_CYC+10 cycles, then send 8'h01 and 8'h02.
  - Required: the first byte is discarded; cmd=16'h0102; no cmd_rdy after the lone 8'hFF.
- Complete command 16'h1111, do not assert clr_cmd_rdy, then complete 16'h2222.
  - Required: cmd=16'h2222, cmd_rdy=1, overrun=1.
  - Then pulse clr_cmd_rdy -> cmd_rdy=0 and overrun=0 on the next cycle.
- Assert clr_cmd_rdy in the same cycle the low byte 8'h77 of pair 8'h66/8'h77 is accepted.
  - Required: cmd_rdy=1 and cmd=16'h6677 on the next cycle.
- Send high byte 8'h55, assert rst_n=0 for 2 cycles, then send 8'hAA and 8'hBB.
  - Required: outputs at reset values during reset; cmd=16'hAABB afterwards.
